// File: rtl/common_pkg.sv
// common_pkg: shared types and helpers for the stream width converters.
//   narrow_state_t - holding-register state (EMPTY / SEND)
//   narrow_idx_t   - slice index for the default 8-to-2 byte configuration
//   narrow_slices  - number of narrow slices a held wide beat produces
package common_pkg;

  localparam int NARROW_IN_BYTS  = 8;
  localparam int NARROW_OUT_BYTS = 2;

  typedef logic [$clog2(NARROW_IN_BYTS/NARROW_OUT_BYTS)-1:0] narrow_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } narrow_state_t;

  // Valid bytes in a wide beat: mod only counts on an eop beat, and mod==0
  // means the whole beat is valid.
  function automatic int narrow_valid_bytes(input int mod, input logic eop,
                                            input int in_byts);
    return (eop && mod != 0) ? mod : in_byts;
  endfunction

  // Slices needed to carry the valid bytes, rounded up (range 1..R).
  function automatic int narrow_slices(input int mod, input logic eop,
                                       input int in_byts, input int out_byts);
    int v;
    v = narrow_valid_bytes(mod, eop, in_byts);
    return (v + out_byts - 1) / out_byts;
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// if_axi_stream: packetised byte stream with ready/valid handshake.
//   val/rdy  - handshake, transfer when both high at the clock edge
//   dat      - 8*BYTS bits, little-endian (byte 0 in dat[7:0])
//   sop/eop  - packet framing
//   mod      - valid bytes on the eop beat, 0 = all BYTS valid
//   err      - packet error flag
//   ctl      - CTL_BITS of opaque sideband
interface if_axi_stream #(
  parameter int BYTS     = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_W = (BYTS > 1) ? $clog2(BYTS) : 1;

  logic                val;
  logic                rdy;
  logic [8*BYTS-1:0]   dat;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_W-1:0]    mod;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, dat, sop, eop, err, mod, ctl, input rdy);
  modport sink   (input  val, dat, sop, eop, err, mod, ctl, output rdy);

endinterface

// File: rtl/axis_width_narrow.sv
// axis_width_narrow: splits each IN_BYTS-wide stream beat into
// IN_BYTS/OUT_BYTS narrow beats, keeping sop/eop/mod/err/ctl framing.
// Short eop beats only emit the slices that carry valid bytes.
//
// Ports:
//   i_clk - clock for the block and both stream interfaces
//   i_rst - synchronous active-high reset
//   i_if  - wide input stream (sink), IN_BYTS / CTL_BITS
//   o_if  - narrow output stream (source), OUT_BYTS / CTL_BITS
//
// Build option:
//   AXIS_WIDTH_NARROW_ERR_ALL_EN - when defined, err is flagged on every
//   slice of an errored beat instead of only on its eop slice.
module axis_width_narrow
  import common_pkg::*;
#(
  parameter int IN_BYTS  = 8,
  parameter int OUT_BYTS = 2,
  parameter int CTL_BITS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_if,
  if_axi_stream.source  o_if
);

  localparam int R      = IN_BYTS / OUT_BYTS;
  localparam int SW     = 8 * OUT_BYTS;
  localparam int IDX_W  = (R > 1) ? $clog2(R) : 1;
  localparam int IMOD_W = (IN_BYTS > 1) ? $clog2(IN_BYTS) : 1;
  localparam int OMOD_W = (OUT_BYTS > 1) ? $clog2(OUT_BYTS) : 1;

  if ((IN_BYTS % OUT_BYTS) != 0 || (IN_BYTS / OUT_BYTS) < 2) begin : g_param_check
    $fatal(1, "axis_width_narrow: IN_BYTS must be a multiple of OUT_BYTS with ratio >= 2");
  end

  // holding register
  narrow_state_t           state_q, state_d;
  logic [R-1:0][SW-1:0]    dat_q;
  logic                    sop_q;
  logic                    eop_q;
  logic                    err_q;
  logic [IMOD_W-1:0]       mod_q;
  logic [CTL_BITS-1:0]     ctl_q;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // decode of the held beat
  int                      v_byts;
  int                      n_slices;
  logic [IDX_W-1:0]        last_idx;
  logic                    hold_val;
  logic                    last;
  logic                    load;
  logic                    eop_out;

  always_comb begin
    v_byts   = narrow_valid_bytes(int'(mod_q), eop_q, IN_BYTS);
    n_slices = narrow_slices(int'(mod_q), eop_q, IN_BYTS, OUT_BYTS);
    last_idx = IDX_W'(n_slices - 1);
  end

  assign hold_val = (state_q == SEND);
  assign last     = (idx_q == last_idx);

  // Ready to take a new beat when empty, or when the final slice of the
  // held beat leaves this cycle. Combinational from o_if.rdy by design.
  assign i_if.rdy = ~i_rst && (~hold_val || (last && o_if.rdy));
  assign load     = i_if.val && i_if.rdy;

  // next state / slice index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (o_if.rdy) begin
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else if (load) begin
            // back-to-back: next beat replaces the held one with no bubble
            idx_d = '0;
          end else begin
            state_d = EMPTY;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      dat_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      mod_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        dat_q <= i_if.dat;
        sop_q <= i_if.sop;
        eop_q <= i_if.eop;
        err_q <= i_if.err;
        mod_q <= i_if.mod;
        ctl_q <= i_if.ctl;
      end
    end
  end

  // Outputs decode only from the holding register and slice index.
  assign eop_out  = hold_val && eop_q && last;

  assign o_if.val = hold_val;
  assign o_if.dat = dat_q[idx_q];
  assign o_if.ctl = ctl_q;
  assign o_if.sop = hold_val && sop_q && (idx_q == '0);
  assign o_if.eop = eop_out;
  assign o_if.mod = eop_out ? OMOD_W'(v_byts % OUT_BYTS) : '0;

`ifdef AXIS_WIDTH_NARROW_ERR_ALL_EN
  // early abort: every slice of an errored beat carries err
  assign o_if.err = hold_val && err_q;
`else
  assign o_if.err = eop_out && err_q;
`endif

endmodule
